// File: rtl/pool_pkg.sv
// Shared constants and helpers for the pooling layers.
package pool_pkg;

  // IEEE-754 single-precision field masks and the canonical quiet NaN
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] EXP_MASK  = 32'h7F80_0000;
  localparam logic [31:0] MANT_MASK = 32'h007F_FFFF;
  localparam logic [31:0] SIGN_BIT  = 32'h8000_0000;

  // Data format encodings
  localparam int FMT_FP32  = 0;
  localparam int FMT_FIXED = 1;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_max_cmp.sv
// Combinational max of two words: signed compare for fixed point,
// sign-magnitude ordering with NaN and signed-zero rules for fp32.
// Operand a is the stored value and wins every tie.
module pool_max_cmp
  import pool_pkg::*;
#(
  parameter int BIT = 32,
  parameter int FMT = FMT_FP32
) (
  input  logic [BIT-1:0] a,
  input  logic [BIT-1:0] b,
  output logic [BIT-1:0] y
);

  if (FMT == FMT_FIXED) begin : g_fixed
    // Two's-complement compare; ties keep a
    always_comb y = ($signed(b) > $signed(a)) ? b : a;
  end else begin : g_fp32
    logic        a_nan, b_nan, a_zero, b_zero, b_gt;
    logic [30:0] a_mag, b_mag;

    // Sign-magnitude ordering, +0 == -0, any NaN collapses to QNAN
    always_comb begin
      a_mag  = a[30:0];
      b_mag  = b[30:0];
      a_nan  = ((a & EXP_MASK) == EXP_MASK) && ((a & MANT_MASK) != '0);
      b_nan  = ((b & EXP_MASK) == EXP_MASK) && ((b & MANT_MASK) != '0);
      a_zero = (a_mag == '0);
      b_zero = (b_mag == '0);
      b_gt   = 1'b0;
      if (a_zero && b_zero)  b_gt = 1'b0;
      else if (a[31] != b[31]) b_gt = !b[31];
      else if (!a[31])       b_gt = (b_mag > a_mag);
      else                   b_gt = (b_mag < a_mag);
      if (a_nan || b_nan) y = QNAN;
      else                y = b_gt ? b : a;
    end
  end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming non-overlapping max pool. Words arrive raster order with the
// channels of each pixel consecutive; only one band of running maxima
// (COL/POOL * CHANNEL words) is kept.
// Handshake: a word moves on a channel when valid && ready in the same
// cycle; in_ready = !out_valid || out_ready, and out_data/out_last stay
// stable while out_valid is high and out_ready is low.
module max_pool_stream
  import pool_pkg::*;
#(
  parameter int BIT     = 32,
  parameter int CHANNEL = 2,
  parameter int COL     = 4,
  parameter int ROW     = 4,
  parameter int POOL    = 2,
  parameter int FMT     = FMT_FP32
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [BIT-1:0] in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [BIT-1:0] out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic           frame_err
);

  localparam int OCOL     = COL / POOL;
  localparam int COL_USED = OCOL * POOL;
  localparam int ROW_USED = (ROW / POOL) * POOL;
  localparam int DEPTH    = OCOL * CHANNEL;
  localparam int CHW      = cnt_w(CHANNEL);
  localparam int COLW     = cnt_w(COL);
  localparam int ROWW     = cnt_w(ROW);
  localparam int AW       = cnt_w(DEPTH);

  logic [CHW-1:0]  ch;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  int              ch_i, col_i, row_i, oc, px, py;
  logic            accept, final_pos, frame_bad;
  logic            in_window, win_first, win_done, wr_en, last_out;
  logic [AW-1:0]   addr;

  logic [BIT-1:0]  acc_mem [DEPTH];
  logic [BIT-1:0]  rd_data, acc_old, max_val, new_val;
  logic            byp_valid;
  logic [AW-1:0]   byp_addr;
  logic [BIT-1:0]  byp_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode the stream position into window coordinates and frame checks
  always_comb begin
    ch_i      = int'(ch);
    col_i     = int'(col);
    row_i     = int'(row);
    oc        = col_i / POOL;
    px        = col_i % POOL;
    py        = row_i % POOL;
    addr      = AW'(oc * CHANNEL + ch_i);
    in_window = (col_i < COL_USED) && (row_i < ROW_USED);
    win_first = (px == 0) && (py == 0);
    win_done  = (px == POOL - 1) && (py == POOL - 1);
    final_pos = (ch_i == CHANNEL - 1) && (col_i == COL - 1) && (row_i == ROW - 1);
    last_out  = (oc == OCOL - 1) && (row_i == ROW_USED - 1) && (ch_i == CHANNEL - 1);
    frame_bad = accept && (in_last != final_pos);
    wr_en     = accept && in_window && !win_done;
  end

  // Partial max for this slot; the bypass returns the word written on the
  // previous edge so the read port may later be moved onto a register
  assign rd_data = acc_mem[addr];
  assign acc_old = (byp_valid && (byp_addr == addr)) ? byp_data : rd_data;
  assign new_val = win_first ? in_data : max_val;

  pool_max_cmp #(.BIT(BIT), .FMT(FMT)) u_cmp (
    .a (acc_old),
    .b (in_data),
    .y (max_val)
  );

  // Accumulator RAM write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) acc_mem[addr] <= new_val;
  end

  // Registered copy of the last RAM write for read-before-write
  always_ff @(posedge clk) begin
    if (rst_) begin
      byp_valid <= 1'b0;
    end else if (wr_en) begin
      byp_valid <= 1'b1;
      byp_addr  <= addr;
      byp_data  <= new_val;
    end
  end

  // Position counters: channel fastest, then column, then row
  always_ff @(posedge clk) begin
    if (rst_) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (frame_bad || final_pos) begin
        ch  <= '0;
        col <= '0;
        row <= '0;
      end else if (ch_i == CHANNEL - 1) begin
        ch <= '0;
        if (col_i == COL - 1) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  // Output register, loaded when a window completes; frame error pulse
  always_ff @(posedge clk) begin
    if (rst_) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (accept && in_window && win_done) begin
        out_valid <= 1'b1;
        out_data  <= new_val;
        out_last  <= last_out;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
